// File: rtl/uart_tx.sv
// UART transmitter: a small input FIFO feeds a frame serialiser. Each frame is a start bit,
// DATA_BITS data bits sent LSB first, an optional parity bit and STOP_BITS stop bits.
module uart_tx #(
  parameter int    DATA_BITS    = 8,
  parameter string PARITY       = "NONE",
  parameter int    STOP_BITS    = 1,
  parameter int    BAUD_DIVIDER = 65535,
  parameter int    FIFO_DEPTH   = 4
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [7:0]                  data,
  input  logic                        valid,
  output logic                        ready,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        txd_out
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam bit PAR_EN   = (PARITY != "NONE");
  localparam bit PAR_INIT = (PARITY == "ODD");

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;

  assign ready      = (count != (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = valid && ready;
  assign fifo_level = count;
  assign head       = mem[rd_ptr][DATA_BITS-1:0];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= data;
  end

  state_t               state, state_nxt;
  logic [15:0]          div_cnt;
  logic                 bit_end;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic                 par, par_nxt, txd_nxt;

  assign bit_end = (div_cnt == 16'(BAUD_DIVIDER - 1));
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    sh_nxt      = sh;
    par_nxt     = par;
    pop         = 1'b0;
    txd_nxt     = 1'b1;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          sh_nxt    = head;
          par_nxt   = PAR_INIT ^ (^head);
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sh_nxt = sh >> 1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt   = S_STOP;
          bit_cnt_nxt = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            // A pending word chains straight into the next start bit with no idle gap.
            if (!empty) begin
              pop       = 1'b1;
              sh_nxt    = head;
              par_nxt   = PAR_INIT ^ (^head);
              state_nxt = S_START;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = sh_nxt[0];
      S_PARITY: txd_nxt = par_nxt;
      default:  txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      par     <= 1'b0;
      div_cnt <= '0;
      txd_out <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      sh      <= sh_nxt;
      par     <= par_nxt;
      div_cnt <= (state == S_IDLE || bit_end) ? '0 : div_cnt + 1'b1;
      txd_out <= txd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: six frame formats side by side, a queue-based line model checked every
// cycle, a bit-sampling receiver model, and directed literal checks.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int NI    = 6;
  localparam int DEPTH = 4;
  localparam int DBA[NI] = '{8, 8, 8, 7, 5, 6};
  localparam int PMA[NI] = '{0, 1, 2, 0, 1, 2};  // 0 none, 1 even, 2 odd
  localparam int SBA[NI] = '{1, 1, 1, 2, 2, 2};
  localparam int BDA[NI] = '{4, 3, 3, 4, 2, 5};

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       valid [NI];
  logic [7:0] data  [NI];
  logic       ready [NI];
  logic       busy  [NI];
  logic       txd   [NI];
  logic [2:0] level [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  uart_tx #(.DATA_BITS(8), .PARITY("NONE"), .STOP_BITS(1), .BAUD_DIVIDER(4), .FIFO_DEPTH(4)) u0 (
    .clk_in(clk_in), .reset(reset), .data(data[0]), .valid(valid[0]), .ready(ready[0]),
    .busy(busy[0]), .fifo_level(level[0]), .txd_out(txd[0]));
  uart_tx #(.DATA_BITS(8), .PARITY("EVEN"), .STOP_BITS(1), .BAUD_DIVIDER(3), .FIFO_DEPTH(4)) u1 (
    .clk_in(clk_in), .reset(reset), .data(data[1]), .valid(valid[1]), .ready(ready[1]),
    .busy(busy[1]), .fifo_level(level[1]), .txd_out(txd[1]));
  uart_tx #(.DATA_BITS(8), .PARITY("ODD"), .STOP_BITS(1), .BAUD_DIVIDER(3), .FIFO_DEPTH(4)) u2 (
    .clk_in(clk_in), .reset(reset), .data(data[2]), .valid(valid[2]), .ready(ready[2]),
    .busy(busy[2]), .fifo_level(level[2]), .txd_out(txd[2]));
  uart_tx #(.DATA_BITS(7), .PARITY("NONE"), .STOP_BITS(2), .BAUD_DIVIDER(4), .FIFO_DEPTH(4)) u3 (
    .clk_in(clk_in), .reset(reset), .data(data[3]), .valid(valid[3]), .ready(ready[3]),
    .busy(busy[3]), .fifo_level(level[3]), .txd_out(txd[3]));
  uart_tx #(.DATA_BITS(5), .PARITY("EVEN"), .STOP_BITS(2), .BAUD_DIVIDER(2), .FIFO_DEPTH(4)) u4 (
    .clk_in(clk_in), .reset(reset), .data(data[4]), .valid(valid[4]), .ready(ready[4]),
    .busy(busy[4]), .fifo_level(level[4]), .txd_out(txd[4]));
  uart_tx #(.DATA_BITS(6), .PARITY("ODD"), .STOP_BITS(2), .BAUD_DIVIDER(5), .FIFO_DEPTH(4)) u5 (
    .clk_in(clk_in), .reset(reset), .data(data[5]), .valid(valid[5]), .ready(ready[5]),
    .busy(busy[5]), .fifo_level(level[5]), .txd_out(txd[5]));

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Line model: the expected txd value of every upcoming cycle, plus the words still queued.
  bit         line_q [NI][$];
  logic [7:0] pend_q [NI][$];
  logic [7:0] sent_q [NI][$];

  function automatic void build_frame(int i, logic [7:0] w);
    bit b[$];
    bit p;
    p = (PMA[i] == 2);
    b.push_back(1'b0);
    for (int k = 0; k < DBA[i]; k++) begin
      b.push_back(w[k]);
      p = p ^ w[k];
    end
    if (PMA[i] != 0) b.push_back(p);
    for (int k = 0; k < SBA[i]; k++) b.push_back(1'b1);
    foreach (b[k]) for (int c = 0; c < BDA[i]; c++) line_q[i].push_back(b[k]);
  endfunction

  always @(posedge clk_in or posedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        line_q[i].delete();
        pend_q[i].delete();
        sent_q[i].delete();
      end else begin
        bit acc;
        acc = valid[i] && (pend_q[i].size() < DEPTH);
        if (line_q[i].size() > 0) void'(line_q[i].pop_front());
        if (line_q[i].size() == 0 && pend_q[i].size() > 0) build_frame(i, pend_q[i].pop_front());
        if (acc) begin
          pend_q[i].push_back(data[i]);
          sent_q[i].push_back(data[i]);
        end
      end
    end
  end

  // Receiver model state
  bit rx_act   [NI];
  int rx_t     [NI];
  bit prev_txd [NI];
  bit rx_b     [NI][$];
  int busy_run [NI];
  int last_run [NI];

  function automatic void rx_check(int i);
    logic [7:0] got  = 8'h00;
    logic [7:0] mask = 8'((1 << DBA[i]) - 1);
    bit p = (PMA[i] == 2);
    int k = 1 + DBA[i];
    chk($sformatf("rx start[%0d]", i), int'(rx_b[i][0]), 0);
    for (int j = 0; j < DBA[i]; j++) begin
      got[j] = rx_b[i][1+j];
      p = p ^ rx_b[i][1+j];
    end
    if (PMA[i] != 0) begin
      chk($sformatf("rx parity[%0d]", i), int'(rx_b[i][k]), int'(p));
      k++;
    end
    for (int j = 0; j < SBA[i]; j++) chk($sformatf("rx stop[%0d]", i), int'(rx_b[i][k+j]), 1);
    n_checks++;
    if (sent_q[i].size() == 0) begin
      n_fail++;
      $display("FAIL rx unexpected frame[%0d]: got byte %02h, expected no frame", i, got);
    end else begin
      logic [7:0] want;
      want = sent_q[i].pop_front() & mask;
      if (got != want) begin
        n_fail++;
        $display("FAIL rx byte[%0d]: got %02h, expected %02h", i, got, want);
      end
    end
  endfunction

  always @(negedge clk_in) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("txd[%0d]", i), int'(txd[i]), line_q[i].size() > 0 ? int'(line_q[i][0]) : 1);
      chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(line_q[i].size() > 0));
      chk($sformatf("level[%0d]", i), int'(level[i]), pend_q[i].size());
      chk($sformatf("ready[%0d]", i), int'(ready[i]), int'(pend_q[i].size() < DEPTH));
      if (busy[i]) busy_run[i]++;
      else begin
        if (busy_run[i] > 0) last_run[i] = busy_run[i];
        busy_run[i] = 0;
      end
      if (reset) begin
        rx_act[i] = 1'b0;
        rx_b[i].delete();
      end else if (!rx_act[i]) begin
        if (prev_txd[i] && !txd[i]) begin
          rx_act[i] = 1'b1;
          rx_t[i]   = 0;
          rx_b[i].delete();
        end
      end else begin
        rx_t[i]++;
      end
      if (rx_act[i] && (rx_t[i] % BDA[i]) == BDA[i] / 2) begin
        rx_b[i].push_back(txd[i]);
        if (rx_b[i].size() == 1 + DBA[i] + (PMA[i] != 0 ? 1 : 0) + SBA[i]) begin
          rx_check(i);
          rx_act[i] = 1'b0;
        end
      end
      prev_txd[i] = txd[i];
    end
  end

  bit cap[$];
  int cap_wait;

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(int i, logic [7:0] b);
    int n = 0;
    valid[i] = 1'b1;
    data[i]  = b;
    while (!ready[i] && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    if (!ready[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL send[%0d]: ready still 0 after %0d cycles, expected 1", i, n);
    end
    @(negedge clk_in);
  endtask

  task automatic capture(int i);
    int n = 0;
    cap.delete();
    while (!busy[i] && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    cap_wait = n;
    while (busy[i] && cap.size() < 2000) begin
      cap.push_back(txd[i]);
      @(negedge clk_in);
    end
  endtask

  task automatic wait_idle(int i);
    int n = 0;
    while ((busy[i] || level[i] != 3'd0) && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle[%0d]: still busy after %0d cycles, expected idle", i, n);
    end
    @(negedge clk_in);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e55[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [7:0] w6[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hC3};
    int cnt;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
    #1 reset = 1'b1;
    @(negedge clk_in);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset txd[%0d]", i), int'(txd[i]), 1);
      chk($sformatf("reset busy[%0d]", i), int'(busy[i]), 0);
      chk($sformatf("reset ready[%0d]", i), int'(ready[i]), 1);
      chk($sformatf("reset level[%0d]", i), int'(level[i]), 0);
    end
    @(negedge clk_in);
    reset = 1'b0;
    repeat (3) @(negedge clk_in);

    // 0x55, no parity, 4 cycles per bit
    send(0, 8'h55);
    valid[0] = 1'b0;
    capture(0);
    chk("t1 push-to-start latency", cap_wait, 1);
    chk("t1 busy length", cap.size(), 40);
    for (int k = 0; k < 10; k++) chk($sformatf("t1 bit %0d", k), int'(cap[k*4+2]), int'(e55[k]));
    @(negedge clk_in);
    chk("t1 busy run", last_run[0], 40);

    // parity bit values
    send(1, 8'h07);
    valid[1] = 1'b0;
    capture(1);
    chk("t2 even frame len", cap.size(), 33);
    chk("t2 even parity 0x07", int'(cap[28]), 1);
    send(2, 8'h07);
    valid[2] = 1'b0;
    capture(2);
    chk("t2 odd frame len", cap.size(), 33);
    chk("t2 odd parity 0x07", int'(cap[28]), 0);
    send(2, 8'h00);
    valid[2] = 1'b0;
    capture(2);
    chk("t2 odd parity 0x00", int'(cap[28]), 1);

    // 7 data bits, 2 stop bits: bit 7 of 0xFF never appears
    send(3, 8'hFF);
    valid[3] = 1'b0;
    capture(3);
    chk("t4 frame len", cap.size(), 40);
    cnt = 0;
    foreach (cap[k]) if (cap[k] == 1'b0) cnt++;
    chk("t4 low cycles", cnt, 4);
    chk("t4 first data", int'(cap[5]), 1);
    wait_idle(3);

    // six back-to-back pushes into a 4-entry FIFO
    for (int k = 0; k < 5; k++) send(0, w6[k]);
    chk("t3 ready after 5", int'(ready[0]), 0);
    chk("t3 level after 5", int'(level[0]), 4);
    send(0, w6[5]);
    valid[0] = 1'b0;
    wait_idle(0);
    @(negedge clk_in);
    chk("t3 contiguous busy run", last_run[0], 240);

    // reset in the middle of a data bit with two words queued
    for (int k = 0; k < 3; k++) send(0, w6[k]);
    valid[0] = 1'b0;
    repeat (6) @(negedge clk_in);
    chk("t5 level before reset", int'(level[0]), 2);
    #1 reset = 1'b1;
    #1;
    chk("t5 txd in reset", int'(txd[0]), 1);
    chk("t5 busy in reset", int'(busy[0]), 0);
    chk("t5 level in reset", int'(level[0]), 0);
    chk("t5 ready in reset", int'(ready[0]), 1);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    cnt = 0;
    repeat (60) begin
      @(negedge clk_in);
      if (busy[0] || !txd[0]) cnt++;
    end
    chk("t5 quiet after reset", cnt, 0);
    send(0, 8'hA5);
    valid[0] = 1'b0;
    wait_idle(0);

    // random bytes through every format, with short random gaps
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 6; k++) begin
        send(i, 8'($urandom_range(0, 255)));
        valid[i] = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk_in);
      end
      wait_idle(i);
    end
    repeat (4) @(negedge clk_in);
    for (int i = 0; i < NI; i++) chk($sformatf("t6 all received[%0d]", i), sent_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
